// File: rtl/cla16_modport.sv
// Registered two-level carry-lookahead adder: {cout,sum} = a + b + cin.
// Define CLA16_OVF_EN to add the registered signed-overflow output ovf.
module cla16_modport #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef CLA16_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_gg;
    logic [NG:0]      w_cg;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_vld;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Group propagate/generate; each term is a flat AND of bit signals.
    always_comb begin : grp_pg
        logic acc;
        logic pp;
        acc  = 1'b0;
        pp   = 1'b0;
        w_gg = '0;
        w_gp = '0;
        for (int m = 0; m < NG; m++) begin
            acc = w_g[m*GROUP+GROUP-1];
            pp  = w_p[m*GROUP+GROUP-1];
            for (int k = GROUP - 2; k >= 0; k--) begin
                acc = acc | (pp & w_g[m*GROUP+k]);
                pp  = pp & w_p[m*GROUP+k];
            end
            w_gg[m] = acc;
            w_gp[m] = pp;
        end
    end

    // Second level: every group carry-in straight from GP/GG and cin.
    always_comb begin : grp_carry
        logic acc;
        logic pp;
        acc     = 1'b0;
        pp      = 1'b0;
        w_cg    = '0;
        w_cg[0] = cin;
        for (int m = 0; m < NG; m++) begin
            acc = w_gg[m];
            pp  = w_gp[m];
            for (int k = m - 1; k >= 0; k--) begin
                acc = acc | (pp & w_gg[k]);
                pp  = pp & w_gp[k];
            end
            w_cg[m+1] = acc | (pp & cin);
        end
    end

    // In-group carries, each expanded from its group carry-in.
    always_comb begin : bit_carry
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b0;
        w_c = '0;
        for (int m = 0; m < NG; m++) begin
            w_c[m*GROUP] = w_cg[m];
            for (int j = 0; j < GROUP - 1; j++) begin
                acc = w_g[m*GROUP+j];
                pp  = w_p[m*GROUP+j];
                for (int k = j - 1; k >= 0; k--) begin
                    acc = acc | (pp & w_g[m*GROUP+k]);
                    pp  = pp & w_p[m*GROUP+k];
                end
                w_c[m*GROUP+j+1] = acc | (pp & w_cg[m]);
            end
        end
        w_c[WIDTH] = w_cg[NG];
    end

    assign w_sum = w_p ^ w_c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_c[WIDTH];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_vld;

`ifdef CLA16_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cla16_modport.sv
// Scoreboard bench for cla16_modport: directed vectors, queued expectations,
// negedge monitor compares every out_valid result.
module tb_cla16_modport;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        in_valid;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;
`ifdef CLA16_OVF_EN
    logic        ovf;
`endif

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    cla16_modport #(.WIDTH(16), .GROUP(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .in_valid (in_valid),
        .sum      (sum),
        .cout     (cout),
        .out_valid(out_valid)
`ifdef CLA16_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic [15:0] es,
                        input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        e.s      = es;
        e.c      = ec;
        e.o      = eo;
        q.push_back(e);
        n_push++;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom);
    endtask

    task automatic chk_hold(input string name, input logic [15:0] es,
                            input logic ec);
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
        chk({name, "_vld"}, 32'(out_valid), 32'd0);
    endtask

    // Monitor: pops the oldest expectation whenever a result is presented
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got sum=%h cout=%b with empty queue",
                         sum, cout);
            end else begin
                exp_t e;
                e = q.pop_front();
                n_pop++;
                chk("sb_sum", 32'(sum), 32'(e.s));
                chk("sb_cout", 32'(cout), 32'(e.c));
`ifdef CLA16_OVF_EN
                chk("sb_ovf", 32'(ovf), 32'(e.o));
`endif
            end
        end
    end

    initial begin
        int budget;
        rst      = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk_hold("reset", 16'h0000, 1'b0);
`ifdef CLA16_OVF_EN
        chk("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;

        send(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        send(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0);
        idle();
        idle();
        chk_hold("hold1", 16'hBCDF, 1'b0);
        idle();
        chk_hold("hold2", 16'hBCDF, 1'b0);

        // Reset while a valid operand pair is presented
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h0100;
        b        = 16'h0200;
        cin      = 1'b0;
        @(negedge clk);
        chk_hold("midrst", 16'h0000, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        send(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
        idle();

        budget = 0;
        while (q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(negedge clk);
        chk("result_count", 32'(n_pop), 32'(n_push));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
